// File: rtl/stolen_monitor_if.sv
// -----------------------------------------------------------------------------
// stolen_monitor_if
//   Groups the scan stream, operator controls and the status outputs of
//   stolen_monitor into one bundle.
//
//   Signals:
//     scan_valid  one item is presented this cycle
//     upc         item UPC code, qualified by scan_valid
//     mark        item carries a security mark, qualified by scan_valid
//     alarm_ack   operator acknowledge, a level that is sampled every cycle
//     clear       synchronous clear of both counters
//     stol        one-cycle pulse: the last accepted item was stolen
//     alarm       latched alarm
//     item_count  number of accepted items, saturating
//     stol_count  number of stolen items, saturating
//     last_upc    UPC of the most recent stolen item (0 when logging is off)
//
//   Modports:
//     master  drives the scan and control inputs and observes the status
//     slave   the monitor itself
// -----------------------------------------------------------------------------
interface stolen_monitor_if #(
    parameter int unsigned UPC_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             scan_valid;
    logic [UPC_W-1:0] upc;
    logic             mark;
    logic             alarm_ack;
    logic             clear;
    logic             stol;
    logic             alarm;
    logic [CNT_W-1:0] item_count;
    logic [CNT_W-1:0] stol_count;
    logic [UPC_W-1:0] last_upc;

    modport master (
        output scan_valid, upc, mark, alarm_ack, clear,
        input  stol, alarm, item_count, stol_count, last_upc
    );

    modport slave (
        input  scan_valid, upc, mark, alarm_ack, clear,
        output stol, alarm, item_count, stol_count, last_upc
    );
endinterface

// File: rtl/stolen_monitor.sv
// -----------------------------------------------------------------------------
// stolen_monitor
//   Watches a stream of scanned items. An item counts as stolen when its UPC
//   belongs to the must-be-marked set (MARK_MASK) and it has no security
//   mark. A stolen item produces a one-cycle stol pulse and raises a latched
//   alarm. The alarm stays up for at least HOLD_CYC cycles; only after that
//   can an operator acknowledge clear it. Saturating counters record the
//   accepted items and the stolen items.
//
//   Optional feature (compile-time macro STOLEN_LOG_EN):
//     defined     last_upc is a register that captures the UPC of each stolen
//                 item
//     undefined   last_upc is tied to 0
//
//   Ports:
//     clk      system clock; all state changes on the rising edge
//     reset_n  asynchronous, active-low reset
//     bus      stolen_monitor_if.slave: scan inputs, alarm_ack, clear,
//              stol, alarm, item_count, stol_count, last_upc
// -----------------------------------------------------------------------------
module stolen_monitor #(
    parameter int unsigned              UPC_W     = 3,
    parameter logic [(2**UPC_W)-1:0]    MARK_MASK = 8'b0011_0001,
    parameter int unsigned              HOLD_CYC  = 4,
    parameter int unsigned              CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    stolen_monitor_if.slave    bus
);

    // At least one bit, so that HOLD_CYC=1 still gives a legal vector.
    localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        StArmed = 2'd0,
        StHold  = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e           state;
    logic [HCW-1:0]   hold_cnt;
    logic             alarm;
    logic             stol;
    logic [CNT_W-1:0] item_count;
    logic [CNT_W-1:0] stol_count;
    logic             hit;

    assign hit = bus.scan_valid & MARK_MASK[bus.upc] & ~bus.mark;

    // The alarm is registered together with the state, so it rises on the
    // same edge that captures the stol pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StArmed;
            hold_cnt <= '0;
            alarm    <= 1'b0;
        end else begin
            unique case (state)
                StArmed: begin
                    if (hit) begin
                        state    <= StHold;
                        hold_cnt <= HOLD_LOAD;
                        alarm    <= 1'b1;
                    end
                end
                StHold: begin
                    // The acknowledge is ignored until the minimum hold has elapsed.
                    if (hit) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state <= StWait;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                StWait: begin
                    // A fresh theft takes priority over a pending acknowledge.
                    if (hit) begin
                        state    <= StHold;
                        hold_cnt <= HOLD_LOAD;
                    end else if (bus.alarm_ack) begin
                        state <= StArmed;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state    <= StArmed;
                    hold_cnt <= '0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stol <= 1'b0;
        end else begin
            stol <= hit;
        end
    end

    // clear wins over a same-cycle increment; both counters hold at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            item_count <= '0;
            stol_count <= '0;
        end else if (bus.clear) begin
            item_count <= '0;
            stol_count <= '0;
        end else begin
            if (bus.scan_valid && (item_count != '1)) begin
                item_count <= item_count + 1'b1;
            end
            if (hit && (stol_count != '1)) begin
                stol_count <= stol_count + 1'b1;
            end
        end
    end

`ifdef STOLEN_LOG_EN
    logic [UPC_W-1:0] last_upc;

    // clear does not affect this register; only reset and a new theft change it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_upc <= '0;
        end else if (hit) begin
            last_upc <= bus.upc;
        end
    end

    assign bus.last_upc = last_upc;
`else
    assign bus.last_upc = '0;
`endif

    assign bus.stol       = stol;
    assign bus.alarm      = alarm;
    assign bus.item_count = item_count;
    assign bus.stol_count = stol_count;

`ifndef SYNTHESIS
    // A stolen pulse is always accompanied by an asserted alarm.
    stol_implies_alarm: assert property (@(posedge clk) disable iff (!reset_n)
        stol |-> alarm);
    // The alarm is high exactly when the FSM is outside ARMED.
    alarm_tracks_state: assert property (@(posedge clk) disable iff (!reset_n)
        alarm == (state != StArmed));
`endif

endmodule
